// File: rtl/time_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : time_ctrl_pkg
// Description : Shared types and limits for the time-of-day load scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package time_ctrl_pkg;

   localparam int SEC_W = 6;
   localparam int HR_W  = 5;

   localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
   localparam logic [SEC_W-1:0] MIN_MAX = 6'd59;
   localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LD_S = 3'd1,
      ST_LD_M = 3'd2,
      ST_LD_H = 3'd3,
      ST_RUN  = 3'd4
   } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Divides clk down to a one-per-CLK_DIV wrap strobe. The strobe
//               is combinational so the caller can register it together with
//               its carry logic in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
   parameter int CLK_DIV = 50,
   parameter int DIV_W   = 6
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam logic [DIV_W-1:0] c_last = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] r_cnt;

   // Count 0..CLK_DIV-1 while enabled; any disabled cycle restarts from 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (!en || (r_cnt == c_last)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign tick = en && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/time_load_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : time_load_scheduler
// Description : Validates time-set requests, sequences them onto the shared
//               load bus (ss, mm, hh), and issues the 1 Hz tick with its
//               minute/hour carry cascade. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module time_load_scheduler
   import time_ctrl_pkg::*;
#(
   parameter int CLK_DIV = 50,
   parameter int DIV_W   = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set_req,
   input  logic [SEC_W-1:0] set_ss,
   input  logic [SEC_W-1:0] set_mm,
   input  logic [HR_W-1:0]  set_hh,
   output logic             ready,
   output logic             set_err,
   output logic [SEC_W-1:0] load_bus,
   output logic             sec_load,
   output logic             min_load,
   output logic             hr_load,
   output logic             load_done,
   input  logic [SEC_W-1:0] sec_val,
   input  logic [SEC_W-1:0] min_val,
   output logic             sec_tick,
   output logic             min_tick,
   output logic             hr_tick,
   output logic             running
);

   sched_state_t     r_state, w_state_nxt;
   logic [SEC_W-1:0] r_ss, r_mm;
   logic [HR_W-1:0]  r_hh;

   logic             w_valid, w_accept, w_pre_en, w_wrap;
   logic [SEC_W-1:0] w_bus_nxt;
   logic             w_sec_load_nxt, w_min_load_nxt, w_hr_load_nxt, w_done_nxt;
   logic             w_err_nxt, w_sec_tick_nxt, w_min_tick_nxt, w_hr_tick_nxt;

   assign w_valid  = (set_ss <= SEC_MAX) && (set_mm <= MIN_MAX) && (set_hh <= HR_MAX);
   assign w_accept = set_req && w_valid && ((r_state == ST_IDLE) || (r_state == ST_RUN));
   // An accepted re-set in RUN stops the prescaler at once, so it also wins over a wrap.
   assign w_pre_en = (r_state == ST_RUN) && !w_accept;

   tick_prescaler #(
      .CLK_DIV (CLK_DIV),
      .DIV_W   (DIV_W)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (w_pre_en),
      .tick (w_wrap)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next state and next output values.
   always_comb begin
      w_state_nxt    = r_state;
      w_bus_nxt      = '0;
      w_sec_load_nxt = 1'b0;
      w_min_load_nxt = 1'b0;
      w_hr_load_nxt  = 1'b0;
      w_done_nxt     = 1'b0;
      w_err_nxt      = 1'b0;
      w_sec_tick_nxt = 1'b0;
      w_min_tick_nxt = 1'b0;
      w_hr_tick_nxt  = 1'b0;
      case (r_state)
         ST_IDLE, ST_RUN: begin
            if (w_accept) begin
               w_state_nxt    = ST_LD_S;
               w_bus_nxt      = set_ss;
               w_sec_load_nxt = 1'b1;
            end else begin
               w_err_nxt      = set_req;
               w_sec_tick_nxt = w_wrap;
               w_min_tick_nxt = w_wrap && (sec_val == SEC_MAX);
               w_hr_tick_nxt  = w_wrap && (sec_val == SEC_MAX) && (min_val == MIN_MAX);
            end
         end
         ST_LD_S: begin
            w_state_nxt    = ST_LD_M;
            w_bus_nxt      = r_mm;
            w_min_load_nxt = 1'b1;
         end
         ST_LD_M: begin
            w_state_nxt   = ST_LD_H;
            w_bus_nxt     = {1'b0, r_hh};
            w_hr_load_nxt = 1'b1;
            w_done_nxt    = 1'b1;
         end
         ST_LD_H: begin
            w_state_nxt = ST_RUN;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Registered outputs; ready/running follow the state being entered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ready     <= 1'b1;
         running   <= 1'b0;
         set_err   <= 1'b0;
         load_bus  <= '0;
         sec_load  <= 1'b0;
         min_load  <= 1'b0;
         hr_load   <= 1'b0;
         load_done <= 1'b0;
         sec_tick  <= 1'b0;
         min_tick  <= 1'b0;
         hr_tick   <= 1'b0;
      end else begin
         ready     <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_RUN);
         running   <= (w_state_nxt == ST_RUN);
         set_err   <= w_err_nxt;
         load_bus  <= w_bus_nxt;
         sec_load  <= w_sec_load_nxt;
         min_load  <= w_min_load_nxt;
         hr_load   <= w_hr_load_nxt;
         load_done <= w_done_nxt;
         sec_tick  <= w_sec_tick_nxt;
         min_tick  <= w_min_tick_nxt;
         hr_tick   <= w_hr_tick_nxt;
      end
   end

   // Shadow copy of an accepted request, replayed during LD_M and LD_H.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ss <= '0;
         r_mm <= '0;
         r_hh <= '0;
      end else if (w_accept) begin
         r_ss <= set_ss;
         r_mm <= set_mm;
         r_hh <= set_hh;
      end
   end

   // The seconds value is driven straight from the input in LD_S; its shadow is kept for completeness of the snapshot.
   logic w_unused_ss;
   assign w_unused_ss = ^r_ss;

endmodule
`default_nettype wire

// File: tb/tb_time_load_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_load_scheduler
// Description : Self-checking bench for time_load_scheduler with a cycle-level
//               reference model of the load/run behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_load_scheduler;

   localparam int CLK_DIV = 4;
   localparam int M_IDLE = 0, M_LDS = 1, M_LDM = 2, M_LDH = 3, M_RUN = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       set_req = 1'b0;
   logic [5:0] set_ss = '0, set_mm = '0;
   logic [4:0] set_hh = '0;
   logic [5:0] sec_val = '0, min_val = '0;
   logic       ready, set_err, sec_load, min_load, hr_load, load_done;
   logic       sec_tick, min_tick, hr_tick, running;
   logic [5:0] load_bus;

   time_load_scheduler #(.CLK_DIV(CLK_DIV), .DIV_W(3)) dut (
      .clk(clk), .rst(rst), .set_req(set_req), .set_ss(set_ss), .set_mm(set_mm),
      .set_hh(set_hh), .ready(ready), .set_err(set_err), .load_bus(load_bus),
      .sec_load(sec_load), .min_load(min_load), .hr_load(hr_load),
      .load_done(load_done), .sec_val(sec_val), .min_val(min_val),
      .sec_tick(sec_tick), .min_tick(min_tick), .hr_tick(hr_tick), .running(running)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference model: mode, cycles elapsed in RUN, latched request
   int m_mode, m_run, m_mm, m_hh;
   logic [5:0] e_bus;
   logic e_ready, e_err, e_sl, e_ml, e_hl, e_done, e_st, e_mt, e_ht, e_run;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_run = 0;
      e_bus = '0; e_err = 0; e_sl = 0; e_ml = 0; e_hl = 0; e_done = 0;
      e_st = 0; e_mt = 0; e_ht = 0; e_run = 0; e_ready = 1;
   endtask

   task automatic model_edge();
      logic valid;
      if (!rst) begin
         model_reset();
         return;
      end
      e_bus = '0; e_err = 0; e_sl = 0; e_ml = 0; e_hl = 0; e_done = 0;
      e_st = 0; e_mt = 0; e_ht = 0;
      valid = (set_ss <= 59) && (set_mm <= 59) && (set_hh <= 23);
      case (m_mode)
         M_IDLE, M_RUN: begin
            if (set_req && valid) begin
               m_mm = set_mm; m_hh = set_hh;
               m_mode = M_LDS; e_bus = set_ss; e_sl = 1;
            end else begin
               e_err = set_req;
               if (m_mode == M_RUN) begin
                  m_run++;
                  if (m_run % CLK_DIV == 0) begin
                     e_st = 1;
                     e_mt = (sec_val == 59);
                     e_ht = e_mt && (min_val == 59);
                  end
               end
            end
         end
         M_LDS: begin m_mode = M_LDM; e_bus = 6'(m_mm); e_ml = 1; end
         M_LDM: begin m_mode = M_LDH; e_bus = 6'(m_hh); e_hl = 1; e_done = 1; end
         default: begin m_mode = M_RUN; m_run = 0; end
      endcase
      e_ready = (m_mode == M_IDLE) || (m_mode == M_RUN);
      e_run   = (m_mode == M_RUN);
   endtask

   task automatic check_all(input string ph);
      chk({ph, ".ready"},     ready,     e_ready);
      chk({ph, ".running"},   running,   e_run);
      chk({ph, ".set_err"},   set_err,   e_err);
      chk({ph, ".load_bus"},  load_bus,  e_bus);
      chk({ph, ".sec_load"},  sec_load,  e_sl);
      chk({ph, ".min_load"},  min_load,  e_ml);
      chk({ph, ".hr_load"},   hr_load,   e_hl);
      chk({ph, ".load_done"}, load_done, e_done);
      chk({ph, ".sec_tick"},  sec_tick,  e_st);
      chk({ph, ".min_tick"},  min_tick,  e_mt);
      chk({ph, ".hr_tick"},   hr_tick,   e_ht);
   endtask

   task automatic step(input string ph);
      @(posedge clk);
      #1;
      model_edge();
      check_all(ph);
   endtask

   task automatic drive_req(input int ss, input int mm, input int hh);
      set_req = 1'b1; set_ss = 6'(ss); set_mm = 6'(mm); set_hh = 5'(hh);
   endtask

   task automatic drive_bad();
      int which;
      which = $urandom_range(0, 2);
      drive_req(which == 0 ? 60 + $urandom_range(0, 3) : $urandom_range(0, 59),
                which == 1 ? 60 + $urandom_range(0, 3) : $urandom_range(0, 59),
                which == 2 ? 24 + $urandom_range(0, 7) : $urandom_range(0, 23));
   endtask

   initial begin
      int first;
      model_reset();

      // reset held for three cycles, then released
      for (int i = 0; i < 3; i++) step("reset");
      rst = 1'b1;
      step("idle");

      // rejected requests in IDLE
      for (int i = 0; i < 3; i++) begin
         drive_bad();
         step("rej_idle");
         set_req = 1'b0;
         step("rej_idle_after");
      end

      // valid set 12:34:05 and first-tick latency
      drive_req(12, 34, 5);
      step("set");
      set_req = 1'b0;
      first = 0;
      for (int i = 2; i <= 20; i++) begin
         step("set_seq");
         if (sec_tick && first == 0) first = i;
      end
      chk("first_tick_latency", first, 8);

      // rejected requests in RUN, ticking continues
      for (int i = 0; i < 4; i++) begin
         drive_bad();
         step("rej_run");
         set_req = 1'b0;
         step("rej_run_after");
      end

      // carry cascade
      sec_val = 6'd59; min_val = 6'd59;
      for (int i = 0; i < 2 * CLK_DIV; i++) step("carry_hr");
      min_val = 6'd10;
      for (int i = 0; i < 2 * CLK_DIV; i++) step("carry_min");
      sec_val = 6'd3;

      // re-set in RUN on a prescaler-wrap cycle
      for (int k = 0; k < CLK_DIV && ((m_run + 1) % CLK_DIV) != 0; k++) step("align");
      chk("wrap_aligned", (m_run + 1) % CLK_DIV, 0);
      drive_req(0, 0, 0);
      step("reset_on_wrap");
      chk("no_tick_on_accept", sec_tick, 1'b0);
      set_req = 1'b0;
      for (int i = 0; i < 12; i++) step("reset_seq");

      // random traffic
      for (int i = 0; i < 200; i++) begin
         set_req = ($urandom_range(0, 7) == 0);
         set_ss  = 6'($urandom_range(0, 63));
         set_mm  = 6'($urandom_range(0, 63));
         set_hh  = 5'($urandom_range(0, 31));
         sec_val = $urandom_range(0, 1) ? 6'd59 : 6'($urandom_range(0, 59));
         min_val = $urandom_range(0, 1) ? 6'd59 : 6'($urandom_range(0, 59));
         step("random");
      end
      set_req = 1'b0;
      for (int i = 0; i < 6; i++) step("drain");

      // reset asserted while in LD_M
      drive_req(7, 8, 9);
      step("mid_ld_s");
      set_req = 1'b0;
      step("mid_ld_m");
      rst = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      for (int i = 0; i < 2; i++) step("held_rst");
      rst = 1'b1;
      for (int i = 0; i < 3; i++) step("after_rst");
      chk("idle_after_rst", {ready, running}, 2'b10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
